adder_station: RTL and testbench

Reservation station plus integer adder for one adder functional-unit slot. It accepts ADD/SUB/ADDI/SUBI instructions issued by the reorder buffer on the CDB instruction bus and fetches operands from the register file and register-status table. It waits on the CDB data bus for any operand still in flight, computes the sum or difference, and pulses the result onto its reorder-buffer slot of the CDB data bus. It is the responder side of the issue/result protocol: one instance per adder FU, and the top level ORs the instances' CDB outputs together.

---
 rtl/adder_station_if.sv | 38 +++
 rtl/adder_station.sv | 181 ++++++++++++++++++
 tb/tb_adder_station.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_station_if.sv
// Issue / register-read / result bus between the reorder buffer side and one
// adder reservation station. The ROB-side agent holds the master modport; the
// station holds the slave modport.
interface adder_station_if #(
    parameter int WORD_SIZE = 32,
    parameter int RB_SIZE   = 8,
    parameter int RB_INDEX  = 4,
    parameter int REG_INDEX = 4,
    parameter int FU_INDEX  = 4
);
    logic [FU_INDEX-1:0]          CDB_inst_fu;
    logic [WORD_SIZE-1:0]         CDB_inst_inst;
    logic [RB_INDEX-1:0]          CDB_inst_RBindex;
    logic [REG_INDEX-1:0]         numj;
    logic [REG_INDEX-1:0]         numk;
    logic [WORD_SIZE-1:0]         vj;
    logic [WORD_SIZE-1:0]         vk;
    logic [RB_INDEX-1:0]          qj;
    logic [RB_INDEX-1:0]          qk;
    logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_in_data;
    logic [RB_SIZE-1:0]           CDB_data_in_valid;
    logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_data;
    logic [RB_SIZE-1:0]           CDB_data_valid;
    logic [RB_SIZE*WORD_SIZE-1:0] CDB_data_addr;
    logic                         busy;

    modport master (
        output CDB_inst_fu, CDB_inst_inst, CDB_inst_RBindex,
        output vj, vk, qj, qk, CDB_data_in_data, CDB_data_in_valid,
        input  numj, numk, CDB_data_data, CDB_data_valid, CDB_data_addr, busy
    );

    modport slave (
        input  CDB_inst_fu, CDB_inst_inst, CDB_inst_RBindex,
        input  vj, vk, qj, qk, CDB_data_in_data, CDB_data_in_valid,
        output numj, numk, CDB_data_data, CDB_data_valid, CDB_data_addr, busy
    );
endinterface

// File: rtl/adder_station.sv
// Single-entry reservation station with an integer add/sub unit. Captures an
// issue, collects operands from the register file or by snooping the result
// bus, waits ADD_LATENCY cycles and pulses the result onto its ROB lane.
module adder_station #(
    parameter int                  WORD_SIZE   = 32,
    parameter int                  RB_SIZE     = 8,
    parameter int                  RB_INDEX    = 4,
    parameter logic [RB_INDEX-1:0] READY       = 4'hF,
    parameter int                  REG_INDEX   = 4,
    parameter int                  FU_INDEX    = 4,
    parameter int                  FU_ID       = 0,
    parameter int                  ADD_LATENCY = 2,
    parameter logic [3:0]          INST_ADD    = 4'h0,
    parameter logic [3:0]          INST_SUB    = 4'h1,
    parameter logic [3:0]          INST_ADDI   = 4'h5,
    parameter logic [3:0]          INST_SUBI   = 4'h6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            kill,
    adder_station_if.slave  bus
);
    localparam int CNT_W = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EXEC = 2'd2,
        DONE = 2'd3
    } state_t;

    // Everything the station remembers about the instruction it holds.
    typedef struct packed {
        state_t               state;
        logic                 sub;
        logic [RB_INDEX-1:0]  tag;
        logic [WORD_SIZE-1:0] opj;
        logic [WORD_SIZE-1:0] opk;
        logic                 rdyj;
        logic                 rdyk;
        logic [RB_INDEX-1:0]  qj;
        logic [RB_INDEX-1:0]  qk;
        logic [CNT_W-1:0]     cnt;
    } slot_t;

    slot_t                        slot_r;
    slot_t                        slot_n;
    logic [RB_SIZE-1:0]           valid_r;
    logic [RB_SIZE-1:0]           valid_n;
    logic [RB_SIZE*WORD_SIZE-1:0] data_r;
    logic [RB_SIZE*WORD_SIZE-1:0] data_n;
    logic                         busy_r;
    logic                         busy_n;
    logic [3:0]                   op_s;
    logic                         sub_s;
    logic                         imm_s;
    logic                         issue_s;
    logic                         hit_j_s;
    logic                         hit_k_s;
    logic                         go_s;
    logic [WORD_SIZE-1:0]         result_s;

    // Tags outside the lane range (including READY) never match a lane.
    function automatic logic lane_hit(input logic [RB_INDEX-1:0] q,
                                      input logic [RB_SIZE-1:0]  vld);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < RB_SIZE; i++) begin
            hit = (q == RB_INDEX'(i)) ? vld[i] : hit;
        end
        return hit;
    endfunction

    function automatic logic [WORD_SIZE-1:0] lane_data(input logic [RB_INDEX-1:0]          q,
                                                       input logic [RB_SIZE*WORD_SIZE-1:0] lanes);
        logic [WORD_SIZE-1:0] d;
        d = '0;
        for (int i = 0; i < RB_SIZE; i++) begin
            d = (q == RB_INDEX'(i)) ? lanes[i*WORD_SIZE +: WORD_SIZE] : d;
        end
        return d;
    endfunction

    assign bus.numj          = bus.CDB_inst_inst[20 +: REG_INDEX];
    assign bus.numk          = bus.CDB_inst_inst[16 +: REG_INDEX];
    assign bus.CDB_data_data  = data_r;
    assign bus.CDB_data_valid = valid_r;
    assign bus.CDB_data_addr  = '0;
    assign bus.busy           = busy_r;

    // Opcode decode; anything unrecognised behaves as a register ADD.
    always_comb begin
        op_s = bus.CDB_inst_inst[WORD_SIZE-1 -: 4];
        case (op_s)
            INST_ADD:  begin sub_s = 1'b0; imm_s = 1'b0; end
            INST_SUB:  begin sub_s = 1'b1; imm_s = 1'b0; end
            INST_ADDI: begin sub_s = 1'b0; imm_s = 1'b1; end
            INST_SUBI: begin sub_s = 1'b1; imm_s = 1'b1; end
            default:   begin sub_s = 1'b0; imm_s = 1'b0; end
        endcase
    end

    // Next-state: capture, operand snooping, latency countdown and result lane.
    always_comb begin
        slot_n   = slot_r;
        issue_s  = (bus.CDB_inst_fu == FU_INDEX'(FU_ID));
        result_s = slot_r.sub ? (slot_r.opj - slot_r.opk) : (slot_r.opj + slot_r.opk);
        case (slot_r.state)
            // DONE also accepts an issue: the slot frees at the edge ending the pulse.
            IDLE, DONE: begin
                if (issue_s) begin
                    slot_n.state = WAIT;
                    slot_n.sub   = sub_s;
                    slot_n.tag   = bus.CDB_inst_RBindex;
                    slot_n.qj    = bus.qj;
                    slot_n.qk    = bus.qk;
                    slot_n.opj   = bus.vj;
                    slot_n.rdyj  = (bus.qj == READY);
                    slot_n.opk   = imm_s ? {{(WORD_SIZE-16){bus.CDB_inst_inst[15]}}, bus.CDB_inst_inst[15:0]}
                                         : bus.vk;
                    slot_n.rdyk  = imm_s | (bus.qk == READY);
                end else begin
                    slot_n.state = IDLE;
                end
            end
            WAIT: begin
                slot_n.state = WAIT;
            end
            EXEC: begin
                if (slot_r.cnt == CNT_W'(0)) begin
                    slot_n.state = DONE;
                end else begin
                    slot_n.cnt = slot_r.cnt - CNT_W'(1);
                end
            end
            default: begin
                slot_n.state = IDLE;
            end
        endcase

        // Pending operands pick up their lane on the same edge, whether that
        // edge is the capture itself (forwarding) or a later waiting edge.
        hit_j_s     = (slot_n.state == WAIT) && !slot_n.rdyj && lane_hit(slot_n.qj, bus.CDB_data_in_valid);
        hit_k_s     = (slot_n.state == WAIT) && !slot_n.rdyk && lane_hit(slot_n.qk, bus.CDB_data_in_valid);
        slot_n.opj  = hit_j_s ? lane_data(slot_n.qj, bus.CDB_data_in_data) : slot_n.opj;
        slot_n.opk  = hit_k_s ? lane_data(slot_n.qk, bus.CDB_data_in_data) : slot_n.opk;
        slot_n.rdyj = slot_n.rdyj | hit_j_s;
        slot_n.rdyk = slot_n.rdyk | hit_k_s;
        go_s         = (slot_n.state == WAIT) && slot_n.rdyj && slot_n.rdyk;
        slot_n.cnt   = go_s ? CNT_W'(ADD_LATENCY - 1) : slot_n.cnt;
        slot_n.state = go_s ? EXEC : slot_n.state;

        busy_n  = (slot_n.state != IDLE);
        valid_n = '0;
        data_n  = '0;
        for (int i = 0; i < RB_SIZE; i++) begin
            valid_n[i] = (slot_n.state == DONE) && (slot_n.tag == RB_INDEX'(i));
            data_n[i*WORD_SIZE +: WORD_SIZE] = valid_n[i] ? result_s : '0;
        end
    end

    // Station state and registered outputs; reset and kill clear them asynchronously.
    always_ff @(posedge clk or negedge reset or posedge kill) begin
        if (!reset) begin
            slot_r  <= '0;
            valid_r <= '0;
            data_r  <= '0;
            busy_r  <= 1'b0;
        end else if (kill) begin
            slot_r  <= '0;
            valid_r <= '0;
            data_r  <= '0;
            busy_r  <= 1'b0;
        end else begin
            slot_r  <= slot_n;
            valid_r <= valid_n;
            data_r  <= data_n;
            busy_r  <= busy_n;
        end
    end
endmodule

// File: tb/tb_adder_station.sv
// Directed bench for adder_station. A timing model predicts, per clock edge,
// when each result is due (ready edge + ADD_LATENCY) and what it must be;
// a negedge process compares every output against it, and hand-computed
// literals pin the key cases.
module tb_adder_station;
    localparam int         W     = 32;
    localparam int         N     = 8;
    localparam int         LAT   = 2;
    localparam logic [3:0] RDY   = 4'hF;
    localparam logic [3:0] MYFU  = 4'h0;

    logic clk;
    logic reset;
    logic kill;

    adder_station_if bus ();

    adder_station #(.FU_ID(0), .ADD_LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .kill  (kill),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model of the held instruction.
    bit          m_act;
    bit          m_sub;
    int          m_tag;
    logic [31:0] m_j;
    logic [31:0] m_k;
    bit          m_rj;
    bit          m_rk;
    logic [3:0]  m_qj;
    logic [3:0]  m_qk;
    int          m_due;
    int          cyc;
    logic          exp_busy;
    logic [N-1:0]  exp_valid;
    logic [N*W-1:0] exp_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        m_act     = 1'b0;
        m_due     = -1;
        exp_busy  = 1'b0;
        exp_valid = '0;
        exp_data  = '0;
    endtask

    // Advance the model across the coming edge using the inputs now driven.
    task automatic model_step();
        logic [3:0]  op;
        logic [31:0] inst;
        int          qi;
        cyc++;
        if (m_act && m_due == cyc - 1) m_act = 1'b0;
        if (!m_act && bus.CDB_inst_fu == MYFU) begin
            inst  = bus.CDB_inst_inst;
            op    = inst[31:28];
            m_act = 1'b1;
            m_due = -1;
            m_tag = int'(bus.CDB_inst_RBindex);
            m_sub = (op == 4'h1) || (op == 4'h6);
            m_qj  = bus.qj;
            m_qk  = bus.qk;
            m_rj  = (bus.qj == RDY);
            m_j   = bus.vj;
            if (op == 4'h5 || op == 4'h6) begin
                m_k  = {{16{inst[15]}}, inst[15:0]};
                m_rk = 1'b1;
            end else begin
                m_k  = bus.vk;
                m_rk = (bus.qk == RDY);
            end
        end
        if (m_act && m_due < 0) begin
            qi = int'(m_qj);
            if (!m_rj && qi < N && bus.CDB_data_in_valid[qi]) begin
                m_j  = bus.CDB_data_in_data[qi*W +: W];
                m_rj = 1'b1;
            end
            qi = int'(m_qk);
            if (!m_rk && qi < N && bus.CDB_data_in_valid[qi]) begin
                m_k  = bus.CDB_data_in_data[qi*W +: W];
                m_rk = 1'b1;
            end
            if (m_rj && m_rk) m_due = cyc + LAT;
        end
        exp_busy  = m_act;
        exp_valid = '0;
        exp_data  = '0;
        if (m_act && m_due == cyc) begin
            exp_valid[m_tag] = 1'b1;
            exp_data[m_tag*W +: W] = m_sub ? (m_j - m_k) : (m_j + m_k);
        end
    endtask

    task automatic idle_inputs();
        bus.CDB_inst_fu       = 4'hF;
        bus.CDB_inst_inst     = '0;
        bus.CDB_inst_RBindex  = '0;
        bus.vj                = '0;
        bus.vk                = '0;
        bus.qj                = RDY;
        bus.qk                = RDY;
        bus.CDB_data_in_data  = '0;
        bus.CDB_data_in_valid = '0;
    endtask

    task automatic issue(input logic [3:0] fu, input logic [31:0] inst, input logic [3:0] rb,
                         input logic [31:0] vj, input logic [31:0] vk,
                         input logic [3:0] qj, input logic [3:0] qk);
        bus.CDB_inst_fu      = fu;
        bus.CDB_inst_inst    = inst;
        bus.CDB_inst_RBindex = rb;
        bus.vj = vj;
        bus.vk = vk;
        bus.qj = qj;
        bus.qk = qk;
    endtask

    task automatic set_lane(input int q, input logic [31:0] val);
        bus.CDB_data_in_valid[q]       = 1'b1;
        bus.CDB_data_in_data[q*W +: W] = val;
    endtask

    // One clock: model the edge, pass it, then return inputs to idle.
    task automatic cycle();
        model_step();
        @(negedge clk);
        #1;
        idle_inputs();
    endtask

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("busy", N*W'(bus.busy), N*W'(exp_busy));
                check("valid", N*W'(bus.CDB_data_valid), N*W'(exp_valid));
                check("data", bus.CDB_data_data, exp_data);
                check("addr", bus.CDB_data_addr, '0);
                check("numj", N*W'(bus.numj), N*W'(bus.CDB_inst_inst[23:20]));
                check("numk", N*W'(bus.numk), N*W'(bus.CDB_inst_inst[19:16]));
            end
        end
    end

    // Directed stimulus with literal expectations.
    initial begin
        reset = 1'b0;
        kill  = 1'b0;
        cyc   = 0;
        idle_inputs();
        model_clear();
        #2;
        check("rst_busy", N*W'(bus.busy), '0);
        check("rst_valid", N*W'(bus.CDB_data_valid), '0);
        check("rst_data", bus.CDB_data_data, '0);
        check("rst_addr", bus.CDB_data_addr, '0);
        @(negedge clk);
        #1;
        reset  = 1'b1;
        chk_en = 1'b1;

        // ADD r3,r1,r2 with both operands ready: 5+7 on lane 2.
        issue(MYFU, 32'h0312_0000, 4'd2, 32'd5, 32'd7, RDY, RDY);
        cycle();
        check("add_busy_e0", N*W'(bus.busy), N*W'(1'b1));
        cycle();
        cycle();
        check("add_valid", N*W'(bus.CDB_data_valid), N*W'(8'b0000_0100));
        check("add_lane2", N*W'(bus.CDB_data_data[2*W +: W]), N*W'(32'd12));
        cycle();
        check("add_busy_end", N*W'(bus.busy), '0);
        check("add_valid_end", N*W'(bus.CDB_data_valid), '0);

        // SUB 0-1 wraps; SUBI issued on the edge that ends its pulse.
        issue(MYFU, 32'h1312_0000, 4'd0, 32'd0, 32'd1, RDY, RDY);
        cycle();
        cycle();
        cycle();
        check("sub_wrap", N*W'(bus.CDB_data_data[0 +: W]), N*W'(32'hFFFF_FFFF));
        issue(MYFU, 32'h6310_FFFF, 4'd7, 32'd3, 32'd99, RDY, 4'd5);
        cycle();
        cycle();
        cycle();
        check("subi_valid", N*W'(bus.CDB_data_valid), N*W'(8'h80));
        check("subi_lane7", N*W'(bus.CDB_data_data[7*W +: W]), N*W'(32'd4));
        cycle();

        // j pending on tag 5, arrives at E0+3; unrelated lane 3 earlier.
        issue(MYFU, 32'h0312_0000, 4'd1, 32'hDEAD_BEEF, 32'd7, 4'd5, RDY);
        cycle();
        set_lane(3, 32'd55);
        cycle();
        check("dep_busy_wait", N*W'(bus.busy), N*W'(1'b1));
        cycle();
        set_lane(5, 32'd100);
        cycle();
        cycle();
        cycle();
        check("dep_valid", N*W'(bus.CDB_data_valid), N*W'(8'b0000_0010));
        check("dep_lane1", N*W'(bus.CDB_data_data[1*W +: W]), N*W'(32'd107));
        cycle();

        // k forwarded from lane 6 on the capture edge itself.
        issue(MYFU, 32'h0312_0000, 4'd3, 32'd1, 32'd0, RDY, 4'd6);
        set_lane(6, 32'd9);
        cycle();
        cycle();
        cycle();
        check("fwd_valid", N*W'(bus.CDB_data_valid), N*W'(8'b0000_1000));
        check("fwd_lane3", N*W'(bus.CDB_data_data[3*W +: W]), N*W'(32'd10));
        cycle();

        // Unknown opcode behaves as ADD.
        issue(MYFU, 32'hF312_0000, 4'd6, 32'd6, 32'd4, RDY, RDY);
        cycle();
        cycle();
        cycle();
        check("unk_lane6", N*W'(bus.CDB_data_data[6*W +: W]), N*W'(32'd10));
        cycle();

        // Kill pulse mid-EXEC, no clock edge inside it.
        issue(MYFU, 32'h0312_0000, 4'd4, 32'd10, 32'd20, RDY, RDY);
        cycle();
        cycle();
        kill = 1'b1;
        #1;
        check("kill_busy", N*W'(bus.busy), '0);
        check("kill_valid", N*W'(bus.CDB_data_valid), '0);
        kill = 1'b0;
        model_clear();
        cycle();
        check("kill_no_pulse", N*W'(bus.CDB_data_valid), '0);
        issue(MYFU, 32'h0312_0000, 4'd5, 32'd2, 32'd3, RDY, RDY);
        cycle();
        cycle();
        cycle();
        check("post_kill_lane5", N*W'(bus.CDB_data_data[5*W +: W]), N*W'(32'd5));
        check("post_kill_valid", N*W'(bus.CDB_data_valid), N*W'(8'h20));
        cycle();

        // Reset asserted while waiting on an operand.
        issue(MYFU, 32'h0312_0000, 4'd2, 32'd0, 32'd7, 4'd5, RDY);
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        check("rst_wait_busy", N*W'(bus.busy), '0);
        check("rst_wait_valid", N*W'(bus.CDB_data_valid), '0);
        check("rst_wait_data", bus.CDB_data_data, '0);
        model_clear();
        reset = 1'b1;
        cycle();
        cycle();

        // Issue addressed to another FU is ignored.
        issue(4'h3, 32'h0312_0000, 4'd2, 32'd5, 32'd7, RDY, RDY);
        cycle();
        check("other_fu_busy", N*W'(bus.busy), '0);
        cycle();
        cycle();
        check("other_fu_valid", N*W'(bus.CDB_data_valid), '0);
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
